// File: rtl/sik_encoder_pkg.sv
// rtl/sik_encoder_pkg.sv - shared SIK opcode, width and thread-slot definitions
package sik_encoder_pkg;

    localparam int WORD_W   = 16;
    localparam int OPCODE_W = 4;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [OPCODE_W-1:0] opcode_t;

    // Normal (immediate-carrying) opcodes
    localparam opcode_t OP_NOARG = 4'h0;
    localparam opcode_t OP_GET   = 4'h1;
    localparam opcode_t OP_POP   = 4'h2;
    localparam opcode_t OP_PUT   = 4'h3;
    localparam opcode_t OP_CALL  = 4'h4;
    localparam opcode_t OP_JUMPF = 4'h5;
    localparam opcode_t OP_JUMP  = 4'h6;
    localparam opcode_t OP_JUMPT = 4'h7;
    localparam opcode_t OP_PUSH  = 4'h8;
    localparam opcode_t OP_PRE   = 4'hF;

    // Extended (no-argument) sub-ops occupy a contiguous range add..test
    localparam opcode_t EXT_ADD  = 4'h1;
    localparam opcode_t EXT_TEST = 4'hC;

    // Interleaved fetch layout: thread 0 on even slots, thread 1 on odd slots
    localparam int THREAD0_BASE = 0;
    localparam int THREAD1_BASE = 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } enc_state_t;

endpackage

// File: rtl/sik_encoder_if.sv
// rtl/sik_encoder_if.sv - instruction input handshake and memory write bus
interface sik_encoder_if #(
    parameter int ADDR_W = 16
);
    import sik_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_thread;
    logic              in_ext;
    opcode_t           in_op;
    word_t             in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_data;
    logic              err;
    logic              wrapped;

    modport master (
        output in_valid, in_thread, in_ext, in_op, in_imm,
        input  in_ready, mem_we, mem_addr, mem_data, err, wrapped
    );

    modport slave (
        input  in_valid, in_thread, in_ext, in_op, in_imm,
        output in_ready, mem_we, mem_addr, mem_data, err, wrapped
    );

endinterface

// File: rtl/sik_word_pack.sv
// rtl/sik_word_pack.sv - opcode legality, prefix decision and word formation
module sik_word_pack
    import sik_encoder_pkg::*;
(
    input  logic    ext,
    input  opcode_t op,
    input  word_t   imm,
    output logic    legal,
    output logic    need_pre,
    output word_t   pre_word,
    output word_t   main_word
);

    // Pure decode; the pre opcode itself is outside both legal ranges
    always_comb begin
        legal     = ext ? (op >= EXT_ADD && op <= EXT_TEST)
                        : (op >= OP_GET  && op <= OP_PUSH);
        need_pre  = !ext && (imm[15:12] != {4{imm[11]}});
        pre_word  = {OP_PRE, 8'h00, imm[15:12]};
        main_word = ext ? {OP_NOARG, 8'h00, op} : {op, imm[11:0]};
    end

endmodule

// File: rtl/sik_encoder.sv
// rtl/sik_encoder.sv - SIK instruction encoder writing interleaved thread memory
module sik_encoder
    import sik_encoder_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    sik_encoder_if.slave  bus
);

    typedef logic [ADDR_W-1:0] addr_t;

    enc_state_t state, next_state;
    logic       rdy_q;
    addr_t      wp0, wp1;
    logic       lat_thread;
    opcode_t    lat_op;
    logic [11:0] lat_imm;

    logic       mem_we_q, err_q, wrapped_q;
    addr_t      mem_addr_q;
    word_t      mem_data_q;

    logic       accept, legal, need_pre;
    word_t      pre_word, main_word;
    logic       wr_en, wr_thread, err_next, latch_en;
    word_t      wr_word;
    addr_t      wr_ptr;
    logic [ADDR_W:0] ptr_sum;

    assign accept        = bus.in_valid && rdy_q;
    assign bus.in_ready  = rdy_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.err       = err_q;
    assign bus.wrapped   = wrapped_q;

    sik_word_pack u_pack (
        .ext       (bus.in_ext),
        .op        (bus.in_op),
        .imm       (bus.in_imm),
        .legal     (legal),
        .need_pre  (need_pre),
        .pre_word  (pre_word),
        .main_word (main_word)
    );

    // Next-state and write selection: IDLE takes new instructions, SECOND finishes a prefixed one
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_thread  = bus.in_thread;
        wr_word    = '0;
        err_next   = 1'b0;
        latch_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        err_next = 1'b1;
                    end else if (need_pre) begin
                        wr_en      = 1'b1;
                        wr_word    = pre_word;
                        latch_en   = 1'b1;
                        next_state = S_SECOND;
                    end else begin
                        wr_en   = 1'b1;
                        wr_word = main_word;
                    end
                end
            end
            S_SECOND: begin
                wr_en      = 1'b1;
                wr_thread  = lat_thread;
                wr_word    = {lat_op, lat_imm};
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The carry out of the +2 step marks a wrap past the top of memory
    assign wr_ptr  = wr_thread ? wp1 : wp0;
    assign ptr_sum = {1'b0, wr_ptr} + (ADDR_W+1)'(2);

    // State, pointers, latched second word and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rdy_q      <= 1'b0;
            wp0        <= addr_t'(THREAD0_BASE);
            wp1        <= addr_t'(THREAD1_BASE);
            lat_thread <= 1'b0;
            lat_op     <= '0;
            lat_imm    <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            err_q      <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state    <= next_state;
            rdy_q    <= (next_state == S_IDLE);
            mem_we_q <= wr_en;
            err_q    <= err_next;
            if (latch_en) begin
                lat_thread <= bus.in_thread;
                lat_op     <= bus.in_op;
                lat_imm    <= bus.in_imm[11:0];
            end
            if (wr_en) begin
                mem_addr_q <= wr_ptr;
                mem_data_q <= wr_word;
                if (wr_thread) wp1 <= ptr_sum[ADDR_W-1:0];
                else           wp0 <= ptr_sum[ADDR_W-1:0];
                if (ptr_sum[ADDR_W]) wrapped_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sik_encoder.sv
// tb/tb_sik_encoder.sv - scoreboard bench for sik_encoder
module tb_sik_encoder;
    import sik_encoder_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sik_encoder_if #(.ADDR_W(16)) bus ();

    sik_encoder #(.ADDR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
        sb.push_back('{1'b0, a, d});
    endtask

    task automatic expect_err();
        sb.push_back('{1'b1, 16'h0, 16'h0});
    endtask

    // Called at #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic t, input logic x, input logic [3:0] op, input logic [15:0] imm);
        int n = 0;
        bus.in_thread = t;
        bus.in_ext    = x;
        bus.in_op     = op;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: every write or err pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.mem_we || bus.err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=we%b_err%b_addr%h_data%h required=none",
                         bus.mem_we, bus.err, bus.mem_addr, bus.mem_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus.err !== mon_e.is_err || bus.mem_we !== !mon_e.is_err ||
                    (!mon_e.is_err && (bus.mem_addr !== mon_e.addr || bus.mem_data !== mon_e.data))) begin
                    errors++;
                    $display("FAIL scoreboard actual=we%b_err%b_addr%h_data%h required=err%b_addr%h_data%h",
                             bus.mem_we, bus.err, bus.mem_addr, bus.mem_data,
                             mon_e.is_err, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_thread = 1'b0;
        bus.in_ext    = 1'b0;
        bus.in_op     = 4'h0;
        bus.in_imm    = 16'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready, 0);
        chk("rst_mem_we",    bus.mem_we,   0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_data",  bus.mem_data, 0);
        chk("rst_err",       bus.err,      0);
        chk("rst_wrapped",   bus.wrapped,  0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", bus.in_ready, 1);

        // Thread 0 push 5: single word at slot 0
        expect_wr(16'h0000, 16'h8005);
        send(1'b0, 1'b0, OP_PUSH, 16'h0005);

        // Thread 1 push 0x1234: prefix then main word, one-cycle stall
        expect_wr(16'h0001, 16'hF001);
        expect_wr(16'h0003, 16'h8234);
        send(1'b1, 1'b0, OP_PUSH, 16'h1234);
        chk("second_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("second_ready_back", bus.in_ready, 1);

        // Sign-extended 12-bit immediate needs no prefix; extended add follows
        expect_wr(16'h0002, 16'h6800);
        send(1'b0, 1'b0, OP_JUMP, 16'hF800);
        expect_wr(16'h0004, 16'h0001);
        send(1'b0, 1'b1, EXT_ADD, 16'hFFFF);

        // Illegal ops: err pulses, no write, pointers untouched
        expect_err();
        send(1'b0, 1'b0, 4'hF, 16'h0000);
        expect_err();
        send(1'b0, 1'b1, 4'hD, 16'h0000);
        expect_wr(16'h0006, 16'h8000);
        send(1'b0, 1'b0, OP_PUSH, 16'h0000);
        expect_wr(16'h0005, 16'h8000);
        send(1'b1, 1'b0, OP_PUSH, 16'h0000);
        drain("drain_basic");
        chk("no_wrap_yet", bus.wrapped, 0);

        // Reset during SECOND drops the pending main word
        expect_wr(16'h0008, 16'hF001);
        send(1'b0, 1'b0, OP_PUSH, 16'h1234);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_second_we", bus.mem_we, 0);
        chk("rst_second_ready", bus.in_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_second_ready_after", bus.in_ready, 1);
        expect_wr(16'h0000, 16'h8007);
        send(1'b0, 1'b0, OP_PUSH, 16'h0007);
        expect_wr(16'h0001, 16'h8007);
        send(1'b1, 1'b0, OP_PUSH, 16'h0007);
        drain("drain_reset");

        // Walk thread 0 to the top of memory and across the wrap
        do_reset();
        for (int i = 0; i < 32767; i++) begin
            expect_wr(16'(2 * i), 16'h8000);
            send(1'b0, 1'b0, OP_PUSH, 16'h0000);
        end
        chk("pre_wrap_flag", bus.wrapped, 0);
        expect_wr(16'hFFFE, 16'h8000);
        send(1'b0, 1'b0, OP_PUSH, 16'h0000);
        chk("wrap_flag_set", bus.wrapped, 1);
        expect_wr(16'h0000, 16'h8000);
        send(1'b0, 1'b0, OP_PUSH, 16'h0000);
        drain("drain_wrap");
        chk("wrap_flag_held", bus.wrapped, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
